ram_dp_be: RTL and testbench

Simple dual-port synchronous RAM with per-byte write enables, selectable read latency, a defined read-during-write policy and a post-reset clear sweep. It replaces the plain `ram` as the CPU data memory, where sub-word stores and a known all-zero initial state are required. It keeps one write port and one read port on a single clock, so existing `ram` instantiations port over by adding `i_wbe` and ignoring the new outputs.

---
 rtl/ram_dp_be.sv | 123 ++++++++++++
 tb/tb_ram_dp_be.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-lane write enables, 1/2-cycle read latency,
// selectable read-during-write policy and a post-reset zeroing sweep.

module ram_dp_be_lane #(
  parameter int AWIDTH = 8,
  parameter int BWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [BWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  input  logic              byp,
  output logic [BWIDTH-1:0] rdata
);
  localparam int DEPTH = 2**AWIDTH;

  logic [BWIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left without reset; only the clear sweep zeroes it.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // byp selects the incoming write byte for a same-address new-data read.
  assign rdata = byp ? wdata : mem[raddr];
endmodule

module ram_dp_be #(
  parameter int AWIDTH       = 8,
  parameter int DWIDTH       = 16,
  parameter int BWIDTH       = 8,
  parameter int RD_LAT       = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1,
  parameter int NLANES       = DWIDTH / BWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic [AWIDTH-1:0] i_raddr,
  input  logic              i_wr,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [NLANES-1:0] i_wbe,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_busy
);
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t                          state, state_nxt;
  logic [AWIDTH-1:0]               clr_ptr;
  logic                            rd_acc;
  logic                            coll;
  logic [AWIDTH-1:0]               mem_waddr;
  logic [NLANES-1:0]               mem_we;
  logic [NLANES-1:0]               byp;
  logic [NLANES-1:0][BWIDTH-1:0]   mem_wdata;
  logic [NLANES-1:0][BWIDTH-1:0]   rd_word;
  logic [1:0]                      vld_pipe;
  logic [1:0][DWIDTH-1:0]          dat_pipe;

  // State register; the sweep pointer only advances while clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_ptr == '1) state_nxt = S_RUN;
  end

  always_comb begin
    o_busy    = 1'b0;
    rd_acc    = 1'b0;
    mem_we    = '0;
    mem_waddr = i_waddr;
    mem_wdata = i_wdata;
    if (state == S_CLEAR) begin
      o_busy    = 1'b1;
      mem_we    = '1;
      mem_waddr = clr_ptr;
      mem_wdata = '0;
    end else begin
      rd_acc = i_rd;
      mem_we = {NLANES{i_wr}} & i_wbe;
    end
  end

  assign coll = (RDW_MODE != 0) && i_wr && (i_waddr == i_raddr);
  assign byp  = {NLANES{coll}} & i_wbe;

  ram_dp_be_lane #(.AWIDTH(AWIDTH), .BWIDTH(BWIDTH)) u_lane [NLANES-1:0] (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (i_raddr),
    .byp   (byp),
    .rdata (rd_word)
  );

  // Data stages only load on a valid so o_rdata holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_acc};
      if (rd_acc)      dat_pipe[0] <= rd_word;
      if (vld_pipe[0]) dat_pipe[1] <= dat_pipe[0];
    end
  end

  assign o_rvalid = (RD_LAT == 2) ? vld_pipe[1] : vld_pipe[0];
  assign o_rdata  = (RD_LAT == 2) ? dat_pipe[1] : dat_pipe[0];
endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (lat1/old-data, lat2/new-data) share one
// stimulus stream and are checked against an array-based memory model.

module tb_ram_dp_be;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rd, i_wr;
  logic [7:0]  i_raddr, i_waddr;
  logic [15:0] i_wdata;
  logic [1:0]  i_wbe;
  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  ram_dp_be #(.AWIDTH(8), .DWIDTH(16), .BWIDTH(8), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .i_rd(i_rd), .i_raddr(i_raddr), .i_wr(i_wr), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_wbe(i_wbe), .o_rdata(rdata_a), .o_rvalid(rvalid_a), .o_busy(busy_a));

  ram_dp_be #(.AWIDTH(8), .DWIDTH(16), .BWIDTH(8), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .i_rd(i_rd), .i_raddr(i_raddr), .i_wr(i_wr), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_wbe(i_wbe), .o_rdata(rdata_b), .o_rvalid(rvalid_b), .o_busy(busy_b));

  logic [15:0] mem_m [256];
  int          clr_left;
  logic        pend_v;
  logic [15:0] pend_d, last_a, last_b;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int k = 0; k < 2; k++) if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
    return r;
  endfunction

  // One clock of stimulus; model updates, then outputs checked 1 time unit after the edge.
  task automatic cyc(input logic rd, input logic [7:0] ra, input logic wr, input logic [7:0] wa,
                     input logic [15:0] wd, input logic [1:0] be);
    logic acc;
    logic [15:0] old, db;
    i_rd = rd; i_raddr = ra; i_wr = wr; i_waddr = wa; i_wdata = wd; i_wbe = be;
    acc = rd && (clr_left == 0);
    old = mem_m[ra];
    db  = (wr && wa == ra) ? merge(old, wd, be) : old;
    if (clr_left > 0) begin
      mem_m[256 - clr_left] = 16'h0;
      clr_left--;
    end else if (wr) begin
      mem_m[wa] = merge(mem_m[wa], wd, be);
    end
    @(posedge clk); #1;
    chk("busy_a", {15'b0, busy_a}, {15'b0, clr_left > 0});
    chk("busy_b", {15'b0, busy_b}, {15'b0, clr_left > 0});
    if (acc) last_a = old;
    chk("rvalid_a", {15'b0, rvalid_a}, {15'b0, acc});
    chk("rdata_a", rdata_a, last_a);
    if (pend_v) last_b = pend_d;
    chk("rvalid_b", {15'b0, rvalid_b}, {15'b0, pend_v});
    chk("rdata_b", rdata_b, last_b);
    pend_v = acc;
    pend_d = db;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h0, 1'b0, 8'h0, 16'h0, 2'b00);
  endtask

  task automatic do_rst(input int hold);
    i_rd = 1'b0; i_wr = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rvalid_a", {15'b0, rvalid_a}, 16'h0);
    chk("rst_rvalid_b", {15'b0, rvalid_b}, 16'h0);
    chk("rst_rdata_a", rdata_a, 16'h0);
    chk("rst_rdata_b", rdata_b, 16'h0);
    chk("rst_busy_a", {15'b0, busy_a}, 16'h1);
    clr_left = 256; pend_v = 1'b0; last_a = 16'h0; last_b = 16'h0;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic sweep(input string tag);
    int n = 0;
    for (int i = 0; i < 300 && busy_a; i++) begin
      idle();
      n++;
    end
    chk(tag, n[15:0], 16'd256);
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    cyc(1'b0, 8'h0, 1'b1, a, d, be);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] e);
    cyc(1'b1, a, 1'b0, 8'h0, 16'h0, 2'b00);
    chk({tag, "_a"}, rdata_a, e);
    idle();
    chk({tag, "_b"}, rdata_b, e);
  endtask

  logic [7:0]  tbl_a [8] = '{8'h05, 8'h3C, 8'h80, 8'hFE, 8'h41, 8'h99, 8'h0A, 8'hC3};
  logic [15:0] tbl_d [8] = '{16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000, 16'hCAFE, 16'h1357, 16'hFFFF, 16'h2468};

  initial begin
    i_rd = 1'b0; i_wr = 1'b0; i_raddr = '0; i_waddr = '0; i_wdata = '0; i_wbe = '0;
    pend_v = 1'b0; pend_d = '0; last_a = '0; last_b = '0; clr_left = 256;
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;
    #2;
    do_rst(3);
    sweep("sweep_len");

    rd_chk("clr_00", 8'h00, 16'h0000);
    rd_chk("clr_7f", 8'h7F, 16'h0000);
    rd_chk("clr_ff", 8'hFF, 16'h0000);

    wr_word(8'h10, 16'h1234, 2'b11);
    wr_word(8'h10, 16'hAB00, 2'b10);
    rd_chk("be_hi", 8'h10, 16'hAB34);
    wr_word(8'h10, 16'hFFFF, 2'b00);
    rd_chk("be_none", 8'h10, 16'hAB34);

    wr_word(8'h20, 16'h5555, 2'b11);
    cyc(1'b1, 8'h20, 1'b1, 8'h20, 16'hAAAA, 2'b11);
    chk("coll_old", rdata_a, 16'h5555);
    idle();
    chk("coll_new", rdata_b, 16'hAAAA);
    wr_word(8'h20, 16'h5555, 2'b11);
    cyc(1'b1, 8'h20, 1'b1, 8'h20, 16'hAAAA, 2'b01);
    chk("coll_old_lo", rdata_a, 16'h5555);
    idle();
    chk("coll_merge", rdata_b, 16'h55AA);
    rd_chk("coll_after", 8'h20, 16'h55AA);

    for (int i = 1; i <= 4; i++) wr_word(8'(i), 16'(i * 16'h0101), 2'b11);
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 8'(i + 1), 1'b0, 8'h0, 16'h0, 2'b00);
      if (i >= 1 && i <= 4) begin
        chk("stream_v", {15'b0, rvalid_b}, 16'h1);
        chk("stream_d", rdata_b, 16'(i * 16'h0101));
      end else begin
        chk("stream_idle", {15'b0, rvalid_b}, 16'h0);
      end
    end

    for (int i = 0; i < 8; i++) wr_word(tbl_a[i], tbl_d[i], 2'b11);
    for (int i = 0; i < 8; i++) rd_chk("table", tbl_a[i], tbl_d[i]);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));

    cyc(1'b1, 8'h01, 1'b0, 8'h0, 16'h0, 2'b00);
    cyc(1'b1, 8'h02, 1'b0, 8'h0, 16'h0, 2'b00);
    do_rst(2);
    chk("inflight_rdata_b", rdata_b, 16'h0);
    sweep("sweep_after_inflight");

    do_rst(2);
    repeat (8'h40) idle();
    do_rst(2);
    sweep("sweep_after_abort");
    rd_chk("abort_zero", 8'h3F, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
